uart_rx_deser_gen: RTL and testbench
====================================

Name: uart_rx_deser_gen

Overview:
Parametrised UART receive deserializer, the next generation of the fixed 8-bit RX shift stage. Accepts one sampled bit per bit period from the RX edge/sample logic and shifts it in when edge_cnt reaches Prescale-1. Adds:
- an internal bit counter and frame FSM
- runtime word length and bit order
- a valid/ready output holding register with overrun detection

Sits between the RX data sampler and the RX FSM/consumer.

Parameters:
DATA_W, 8, maximum data bits per frame (>=5)
PRESC_W, 6, width of edge_cnt and Prescale
LEN_W, $clog2(DATA_W+1), width of data_len

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-low
deser_en  in  1  shift qualify from RX FSM
sample_bit  in  1  majority-sampled RX bit
edge_cnt  in  PRESC_W  oversampling edge counter
Prescale  in  PRESC_W  oversampling ratio
data_len  in  LEN_W  data bits per frame, 5..DATA_W
msb_first  in  1  1: MSB first, 0: LSB first (UART default)
frame_start  in  1  pulse: abort partial word, restart count
data_ready  in  1  consumer accepts P_DATA
P_DATA  out  DATA_W  received word, right-aligned, upper bits zero
data_valid  out  1  P_DATA holds an unconsumed word
overrun  out  1  one-cycle pulse: completed word dropped

Behaviour:
- Reset values:
  - P_DATA=0, data_valid=0, overrun=0, par_err=0 (macro)
  - shift reg=0, bit_cnt=0, state IDLE
- strobe = deser_en && (edge_cnt == Prescale-1). Subtraction is PRESC_W wide and wraps: Prescale=0 compares against all-ones.
- Config latch:
  - data_len and msb_first are latched on the first strobe in IDLE and held for the whole frame.
  - data_len of 0..4 or >DATA_W is clamped to DATA_W.
- Shift on strobe:
  - LSB-first: sr <= {sample_bit, sr[DATA_W-1:1]}.
  - MSB-first: sr <= {sr[DATA_W-2:0], sample_bit}.
- FSM:
  - IDLE: on strobe -> SHIFT, bit_cnt=1.
  - SHIFT: each strobe increments bit_cnt. On the strobe where bit_cnt==len-1, go to DONE (combinational, same cycle): the word is formed from the shifted value including the current bit.
  - DONE: -> IDLE, bit_cnt=0.
  - PARITY state exists only with the macro.
- Alignment at completion:
  - LSB-first word = shifted value >> (DATA_W-len).
  - MSB-first word = shifted value masked to len bits.
- Output register, updated the cycle after the completing strobe (latency 1 clock):
  - data_valid=0: load P_DATA, data_valid<=1.
  - data_valid=1 and data_ready=1 same cycle: load new word, data_valid stays 1, no overrun.
  - data_valid=1 and data_ready=0: word discarded, P_DATA unchanged, overrun=1 for one cycle.
  - Otherwise, data_ready=1 with data_valid=1 clears data_valid.
- frame_start has priority over strobe in the same cycle: sr and bit_cnt clear, state -> IDLE, and that strobe is ignored. The output register is untouched.
- deser_en low: no shift, counter holds.
- RST asserted mid-frame clears everything immediately; there is no partial-word output.

Optional Feature:
UART_RX_DESER_PARITY_EN
- Enabled:
  - Adds inputs par_en (1) and par_type (1; 0 even, 1 odd) and output par_err (1).
  - With par_en=1, after the last data bit the FSM enters PARITY. The next strobe samples the parity bit and the frame completes there.
  - par_err is computed as (^word ^ parity_bit) != par_type. It is loaded and cleared together with P_DATA/data_valid.
- Disabled: ports absent, frame completes after the data bits, no PARITY state.

Decomposition:
- Package uart_rx_pkg holds:
  - FSM state enum (IDLE, SHIFT, PARITY, DONE)
  - PAR_EVEN/PAR_ODD constants
  - MIN_DATA_LEN=5
  - clamp_len function
- One sub-module, uart_rx_out_reg: the valid/ready holding register with overrun generation, parametrised on DATA_W.

Test Plan:
1. DATA_W=8, Prescale=8, LSB-first, len=8, bits 1,0,1,0,0,1,0,1 at edge_cnt=7 -> P_DATA=0xA5, data_valid high 1 clock after the 8th strobe.
2. MSB-first, len=5, bits 1,0,1,1,0 -> P_DATA=0x16.
3. LSB-first, len=7, bits of 0x55 -> P_DATA=0x55; len=3 -> clamped, 8 strobes are needed for completion.
4. Two 0xA5/0x3C frames with data_ready=0 -> overrun pulses 1 cycle at 2nd completion, P_DATA stays 0xA5; 2nd completion coinciding with data_ready=1 -> P_DATA=0x3C, no overrun.
5. frame_start after 3 bits, then 8 bits of 0x3C -> P_DATA=0x3C. RST low mid-frame -> all outputs 0, next full frame is received correctly.
6. Macro on, par_en=1, even parity, 0xA5 with parity bit 0 -> par_err=0; with parity bit 1 -> par_err=1, data_valid after the 9th strobe.

Source files
------------

// File: rtl/uart_rx_deser_gen_pkg.sv
// Shared types and helpers for the UART RX deserializer (uart_rx_pkg).
// Optional parity support is selected with UART_RX_DESER_PARITY_EN.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned MIN_DATA_LEN = 5;

  // Out-of-range word lengths fall back to the widest supported frame.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len < MIN_DATA_LEN || len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_deser_gen_out_reg.sv
// Valid/ready holding register for received words with overrun pulse.
// Parity error flag travels with the word when UART_RX_DESER_PARITY_EN is set.
module uart_rx_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
`ifdef UART_RX_DESER_PARITY_EN
  input  logic              par_in,
  output logic              par_err,
`endif
  input  logic              data_ready,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              par_err_q, par_err_d;

  // Accept a new word when empty or being drained, otherwise flag overrun.
  always_comb begin
    p_data_d  = p_data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    par_err_d = par_err_q;
    if (load) begin
      if (!valid_q || data_ready) begin
        p_data_d = word;
        valid_d  = 1'b1;
`ifdef UART_RX_DESER_PARITY_EN
        par_err_d = par_in;
`else
        par_err_d = 1'b0;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d   = 1'b0;
      par_err_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      par_err_q <= par_err_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_DESER_PARITY_EN
  assign par_err    = par_err_q;
`else
  logic unused_par;
  assign unused_par = par_err_q;
`endif

endmodule

// File: rtl/uart_rx_deser_gen.sv
// UART RX deserializer: bit counter, frame FSM, runtime length/bit order,
// and a valid/ready output stage. Parity: define UART_RX_DESER_PARITY_EN.
module uart_rx_deser_gen
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned LEN_W   = $clog2(DATA_W + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               deser_en,
  input  logic               sample_bit,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [LEN_W-1:0]   data_len,
  input  logic               msb_first,
  input  logic               frame_start,
  input  logic               data_ready,
`ifdef UART_RX_DESER_PARITY_EN
  input  logic               par_en,
  input  logic               par_type,
  output logic               par_err,
`endif
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               overrun
);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              msb_q, msb_d;
`ifdef UART_RX_DESER_PARITY_EN
  logic              par_en_q, par_en_d;
  logic              par_type_q, par_type_d;
`endif

  logic [PRESC_W-1:0] presc_m1;
  logic               strobe;
  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   len_eff;
  logic               msb_eff;
  logic [DATA_W-1:0]  sr_shift;
  logic [DATA_W-1:0]  align_src;
  logic [DATA_W-1:0]  len_mask;
  logic [LEN_W-1:0]   shamt;
  logic [DATA_W-1:0]  word;
  logic               word_done;
  logic               par_calc;

  // Strobe at the last oversampling edge of each bit period (wrapping compare).
  always_comb begin
    presc_m1 = Prescale - PRESC_W'(1);
    strobe   = deser_en && (edge_cnt == presc_m1);
  end

  // Effective frame config: live inputs in IDLE (latch cycle), held values after.
  always_comb begin
    len_clamped = LEN_W'(clamp_len(32'(data_len), DATA_W));
    len_eff     = (state_q == IDLE) ? len_clamped : len_q;
    msb_eff     = (state_q == IDLE) ? msb_first   : msb_q;
    sr_shift    = msb_eff ? {sr_q[DATA_W-2:0], sample_bit}
                          : {sample_bit, sr_q[DATA_W-1:1]};
  end

  // Right-align the received bits; parity completion uses the held shift value.
  always_comb begin
`ifdef UART_RX_DESER_PARITY_EN
    align_src = (state_q == PARITY) ? sr_q : sr_shift;
`else
    align_src = sr_shift;
`endif
    shamt    = LEN_W'(DATA_W) - len_eff;
    len_mask = ~({DATA_W{1'b1}} << len_eff);
    word     = msb_eff ? (align_src & len_mask) : (align_src >> shamt);
  end

  // Frame FSM: next state, shift register, bit counter and config latch.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    msb_d     = msb_q;
    word_done = 1'b0;
    par_calc  = 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
`endif
    if (frame_start) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (strobe) begin
            sr_d    = sr_shift;
            cnt_d   = LEN_W'(1);
            len_d   = len_clamped;
            msb_d   = msb_first;
`ifdef UART_RX_DESER_PARITY_EN
            par_en_d   = par_en;
            par_type_d = par_type;
`endif
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (strobe) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
`ifdef UART_RX_DESER_PARITY_EN
              if (par_en_q) begin
                state_d = PARITY;
              end else begin
                state_d   = DONE;
                word_done = 1'b1;
              end
`else
              state_d   = DONE;
              word_done = 1'b1;
`endif
            end
          end
        end
        PARITY: begin
`ifdef UART_RX_DESER_PARITY_EN
          if (strobe) begin
            state_d   = DONE;
            word_done = 1'b1;
            par_calc  = ((^word) ^ sample_bit) != par_type_q;
          end
`else
          state_d = IDLE;
`endif
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_W'(DATA_W);
      msb_q   <= 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
`ifdef UART_RX_DESER_PARITY_EN
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
`endif
    end
  end

`ifndef UART_RX_DESER_PARITY_EN
  logic unused_calc;
  assign unused_calc = par_calc;
`endif

  uart_rx_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .CLK        (CLK),
    .RST        (RST),
    .load       (word_done),
    .word       (word),
`ifdef UART_RX_DESER_PARITY_EN
    .par_in     (par_calc),
    .par_err    (par_err),
`endif
    .data_ready (data_ready),
    .p_data     (P_DATA),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_uart_rx_deser_gen.sv
// Directed bench for uart_rx_deser_gen (DATA_W=8, PRESC_W=6).
module tb_uart_rx_deser_gen;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PRESC_W = 6;
  localparam int unsigned LEN_W   = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               deser_en = 1'b0;
  logic               sample_bit = 1'b0;
  logic [PRESC_W-1:0] edge_cnt = '0;
  logic [PRESC_W-1:0] Prescale = 6'd8;
  logic [LEN_W-1:0]   data_len = 4'd8;
  logic               msb_first = 1'b0;
  logic               frame_start = 1'b0;
  logic               data_ready = 1'b0;
  logic [DATA_W-1:0]  P_DATA;
  logic               data_valid;
  logic               overrun;
`ifdef UART_RX_DESER_PARITY_EN
  logic               par_en = 1'b0;
  logic               par_type = 1'b0;
  logic               par_err;
`endif

  uart_rx_deser_gen #(
    .DATA_W  (DATA_W),
    .PRESC_W (PRESC_W),
    .LEN_W   (LEN_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .deser_en    (deser_en),
    .sample_bit  (sample_bit),
    .edge_cnt    (edge_cnt),
    .Prescale    (Prescale),
    .data_len    (data_len),
    .msb_first   (msb_first),
    .frame_start (frame_start),
    .data_ready  (data_ready),
`ifdef UART_RX_DESER_PARITY_EN
    .par_en      (par_en),
    .par_type    (par_type),
    .par_err     (par_err),
`endif
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .overrun     (overrun)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic ready_on_strobe = 1'b0;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic             msb;
    int               nbits;
    logic [7:0]       bits;  // bits[i] is the i-th bit on the line
    logic [7:0]       exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One bit period: a non-strobe edge, a gated (deser_en low) strobe edge, then the real strobe.
  task automatic send_bit(input logic b, input bit chk_idle);
    logic [PRESC_W-1:0] pm1;
    pm1 = Prescale - 6'd1;
    edge_cnt = 6'd3; deser_en = 1'b1; sample_bit = ~b;
    tick();
    edge_cnt = pm1; deser_en = 1'b0; sample_bit = b;
    tick();
    if (chk_idle) check("valid_before_last", {31'd0, data_valid}, 32'd0);
    edge_cnt = pm1; deser_en = 1'b1; sample_bit = b; data_ready = ready_on_strobe;
    tick();
    deser_en = 1'b0; edge_cnt = '0; data_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bits, input int first, input int n, input bit chk);
    for (int i = first; i < first + n; i++) begin
      send_bit(bits[i], chk && (i == first + n - 1));
    end
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd8,  1'b0, 8, 8'hA5, 8'hA5};  // LSB-first full byte
    vecs[1] = '{4'd5,  1'b1, 5, 8'h0D, 8'h16};  // MSB-first 1,0,1,1,0
    vecs[2] = '{4'd7,  1'b0, 7, 8'h55, 8'h55};  // LSB-first 7 bits
    vecs[3] = '{4'd3,  1'b0, 8, 8'h3C, 8'h3C};  // len 3 clamps to 8
    vecs[4] = '{4'd8,  1'b1, 8, 8'hA3, 8'hC5};  // MSB-first 1,1,0,0,0,1,0,1
    vecs[5] = '{4'd5,  1'b0, 5, 8'h0B, 8'h0B};  // LSB-first 5 bits, upper zero
    vecs[6] = '{4'd6,  1'b1, 6, 8'h39, 8'h27};  // MSB-first 1,0,0,1,1,1
    vecs[7] = '{4'd15, 1'b0, 8, 8'h81, 8'h81};  // len above DATA_W clamps

    // Reset state
    tick();
    tick();
    check("rst_pdata",   {24'd0, P_DATA}, 32'd0);
    check("rst_valid",   {31'd0, data_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    RST = 1'b1;
    tick();

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      data_len  = vecs[v].len;
      msb_first = vecs[v].msb;
      send_frame(vecs[v].bits, 0, vecs[v].nbits, 1'b1);
      check($sformatf("vec%0d_valid", v), {31'd0, data_valid}, 32'd1);
      check($sformatf("vec%0d_pdata", v), {24'd0, P_DATA}, {24'd0, vecs[v].exp});
      check($sformatf("vec%0d_overrun", v), {31'd0, overrun}, 32'd0);
      consume();
      check($sformatf("vec%0d_consumed", v), {31'd0, data_valid}, 32'd0);
    end

    // Config latched on first strobe: changes mid-frame are ignored
    data_len = 4'd8; msb_first = 1'b0;
    send_frame(8'hA5, 0, 1, 1'b0);
    data_len = 4'd5; msb_first = 1'b1;
    send_frame(8'hA5, 1, 7, 1'b1);
    check("latch_pdata", {24'd0, P_DATA}, 32'hA5);
    check("latch_valid", {31'd0, data_valid}, 32'd1);
    consume();
    data_len = 4'd8; msb_first = 1'b0;

    // Overrun: second word dropped while first unconsumed
    send_frame(8'hA5, 0, 8, 1'b1);
    send_frame(8'h3C, 0, 8, 1'b0);
    check("ovr_pulse", {31'd0, overrun}, 32'd1);
    check("ovr_pdata_kept", {24'd0, P_DATA}, 32'hA5);
    check("ovr_valid", {31'd0, data_valid}, 32'd1);
    tick();
    check("ovr_pulse_end", {31'd0, overrun}, 32'd0);
    consume();
    check("ovr_consumed", {31'd0, data_valid}, 32'd0);

    // Completion coinciding with data_ready replaces the word
    send_frame(8'hA5, 0, 8, 1'b1);
    send_frame(8'h3C, 0, 7, 1'b0);
    ready_on_strobe = 1'b1;
    send_frame(8'h3C, 7, 1, 1'b0);
    ready_on_strobe = 1'b0;
    check("rdy_pdata", {24'd0, P_DATA}, 32'h3C);
    check("rdy_valid", {31'd0, data_valid}, 32'd1);
    check("rdy_no_overrun", {31'd0, overrun}, 32'd0);
    consume();
    check("rdy_consumed", {31'd0, data_valid}, 32'd0);
    check("rdy_pdata_held", {24'd0, P_DATA}, 32'h3C);

    // frame_start wins over a simultaneous strobe
    send_frame(8'hFF, 0, 3, 1'b0);
    edge_cnt = Prescale - 6'd1; deser_en = 1'b1; sample_bit = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; deser_en = 1'b0; edge_cnt = '0;
    check("fs_no_output", {31'd0, data_valid}, 32'd0);
    send_frame(8'h3C, 0, 8, 1'b1);
    check("fs_pdata", {24'd0, P_DATA}, 32'h3C);
    check("fs_valid", {31'd0, data_valid}, 32'd1);
    consume();

    // Asynchronous reset mid-frame
    send_frame(8'h81, 0, 8, 1'b1);
    send_frame(8'hFF, 0, 4, 1'b0);
    #2 RST = 1'b0;
    #1;
    check("arst_pdata",   {24'd0, P_DATA}, 32'd0);
    check("arst_valid",   {31'd0, data_valid}, 32'd0);
    check("arst_overrun", {31'd0, overrun}, 32'd0);
    tick();
    RST = 1'b1;
    tick();
    send_frame(8'hA5, 0, 8, 1'b1);
    check("arst_next_pdata", {24'd0, P_DATA}, 32'hA5);
    check("arst_next_valid", {31'd0, data_valid}, 32'd1);
    consume();

    // Prescale=0 strobes at edge_cnt all-ones
    Prescale = 6'd0;
    send_frame(8'h5A, 0, 8, 1'b1);
    check("presc0_pdata", {24'd0, P_DATA}, 32'h5A);
    check("presc0_valid", {31'd0, data_valid}, 32'd1);
    consume();
    Prescale = 6'd8;

`ifdef UART_RX_DESER_PARITY_EN
    // Even parity: 0xA5 has four ones
    par_en = 1'b1; par_type = 1'b0;
    send_frame(8'hA5, 0, 8, 1'b0);
    send_frame(8'h00, 0, 1, 1'b1);
    check("par_ok_valid", {31'd0, data_valid}, 32'd1);
    check("par_ok_pdata", {24'd0, P_DATA}, 32'hA5);
    check("par_ok_err",   {31'd0, par_err}, 32'd0);
    consume();
    send_frame(8'hA5, 0, 8, 1'b0);
    send_frame(8'h01, 0, 1, 1'b1);
    check("par_bad_valid", {31'd0, data_valid}, 32'd1);
    check("par_bad_err",   {31'd0, par_err}, 32'd1);
    consume();
    check("par_err_cleared", {31'd0, par_err}, 32'd0);
    par_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
